// File: rtl/access_code_sender_pkg.sv
// Shared types and constants for the access-code initiator and the turnstile side.
package access_if_pkg;

  localparam int CODE_W = 4;
  localparam logic [1:0] RESP_IDLE = 2'b00;

  typedef enum logic [2:0] {
    ENTRY,
    REQ,
    WAIT_RESP,
    GRANTED,
    LOCKOUT
  } sender_state_t;

  // Consecutive-denial counter never wraps past 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/access_code_sender_if.sv
// Request/response handshake between the access-code sender and the turnstile FSM.
interface access_code_sender_if;
  import access_if_pkg::*;

  logic              validate_code;
  logic [CODE_W-1:0] access_code;
  logic              door_open;
  logic [1:0]        resp_state;

  modport master (
    output validate_code,
    output access_code,
    input  door_open,
    input  resp_state
  );

  modport slave (
    input  validate_code,
    input  access_code,
    output door_open,
    output resp_state
  );

endinterface

// File: rtl/access_code_sender_cycle_timer.sv
// Loadable up-counter that flags when it sits on its terminal value.
module cycle_timer #(
  parameter int TERMINAL = 3,
  parameter int WIDTH    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);

  logic [WIDTH-1:0] count;

  // Load returns the count to zero; enable advances it by one.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/access_code_sender.sv
// Initiator side of the turnstile access-code interface: keypad digit capture,
// request strobe, grant/deny classification and lockout after repeated denials.
module access_code_sender
  import access_if_pkg::*;
#(
  parameter int RESP_TIMEOUT   = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [CODE_W-1:0] key_value,
  input  logic              key_enter,
  input  logic              key_clear,
  access_code_sender_if.master turnstile,
  output logic              busy,
  output logic              grant_pulse,
  output logic              deny_pulse,
  output logic              locked_out,
  output logic [3:0]        fail_count
);

  localparam int RESP_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  sender_state_t     state;
  logic [CODE_W-1:0] code_reg;
  logic              has_digit;
  logic              validate_q;
  logic              resp_done;
  logic              lock_done;
  logic [3:0]        next_fails;

  assign next_fails = sat_inc4(fail_count);

  assign turnstile.validate_code = validate_q;
  assign turnstile.access_code   = code_reg;

  cycle_timer #(
    .TERMINAL (RESP_TIMEOUT - 1),
    .WIDTH    (RESP_W)
  ) u_resp_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state != WAIT_RESP),
    .enable (state == WAIT_RESP),
    .done   (resp_done)
  );

  cycle_timer #(
    .TERMINAL (LOCKOUT_CYCLES - 1),
    .WIDTH    (LOCK_W)
  ) u_lock_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state != LOCKOUT),
    .enable (state == LOCKOUT),
    .done   (lock_done)
  );

  // Main sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ENTRY;
      code_reg    <= '0;
      has_digit   <= 1'b0;
      validate_q  <= 1'b0;
      busy        <= 1'b0;
      grant_pulse <= 1'b0;
      deny_pulse  <= 1'b0;
      locked_out  <= 1'b0;
      fail_count  <= 4'd0;
    end else begin
      grant_pulse <= 1'b0;
      deny_pulse  <= 1'b0;
      validate_q  <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (key_clear) begin
            code_reg  <= '0;
            has_digit <= 1'b0;
          end else begin
            if (key_valid) begin
              code_reg  <= key_value;
              has_digit <= 1'b1;
            end
            if (key_enter && (has_digit || key_valid)) begin
              state <= REQ;
              busy  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (validate_q) begin
            state <= WAIT_RESP;
          end else if (turnstile.resp_state == RESP_IDLE) begin
            validate_q <= 1'b1;
          end
        end
        WAIT_RESP: begin
          if (turnstile.door_open) begin
            state       <= GRANTED;
            grant_pulse <= 1'b1;
            fail_count  <= 4'd0;
          end else if (resp_done) begin
            deny_pulse <= 1'b1;
            fail_count <= next_fails;
            if (next_fails == 4'(MAX_FAILS)) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state     <= ENTRY;
              busy      <= 1'b0;
              code_reg  <= '0;
              has_digit <= 1'b0;
            end
          end
        end
        GRANTED: begin
          if (!turnstile.door_open) begin
            state     <= ENTRY;
            busy      <= 1'b0;
            code_reg  <= '0;
            has_digit <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (lock_done) begin
            state      <= ENTRY;
            busy       <= 1'b0;
            locked_out <= 1'b0;
            fail_count <= 4'd0;
            code_reg   <= '0;
            has_digit  <= 1'b0;
          end
        end
        default: begin
          state <= ENTRY;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_access_code_sender.sv
// Self-checking bench for access_code_sender: the bench plays keypad and turnstile,
// and predicts every output per cycle from the protocol timing rules.
module tb_access_code_sender;

  localparam int RESP_TIMEOUT   = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 32;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_value;
  logic       key_enter;
  logic       key_clear;
  logic       busy;
  logic       grant_pulse;
  logic       deny_pulse;
  logic       locked_out;
  logic [3:0] fail_count;

  int checks;
  int errors;
  int fails;
  logic [3:0] secret;

  access_code_sender_if tif();

  access_code_sender #(
    .RESP_TIMEOUT   (RESP_TIMEOUT),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_value   (key_value),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .turnstile   (tif),
    .busy        (busy),
    .grant_pulse (grant_pulse),
    .deny_pulse  (deny_pulse),
    .locked_out  (locked_out),
    .fail_count  (fail_count)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input int t, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s t=%0d observed=%0h expected=%0h", tag, t, observed, expected);
    end
  endtask

  task automatic compare_all(input int t, input logic v, input logic g, input logic d,
                             input logic l, input logic b, input logic [3:0] c,
                             input logic [3:0] f);
    check_output("validate_code", t, 8'(tif.validate_code), 8'(v));
    check_output("grant_pulse",   t, 8'(grant_pulse),       8'(g));
    check_output("deny_pulse",    t, 8'(deny_pulse),        8'(d));
    check_output("locked_out",    t, 8'(locked_out),        8'(l));
    check_output("busy",          t, 8'(busy),              8'(b));
    check_output("access_code",   t, 8'(tif.access_code),   8'(c));
    check_output("fail_count",    t, 8'(fail_count),        8'(f));
  endtask

  task automatic apply_stimulus(input logic v, input logic [3:0] val, input logic e,
                                input logic c);
    key_valid = v;
    key_value = val;
    key_enter = e;
    key_clear = c;
  endtask

  // One complete transaction. The turnstile grants when the code matches the secret;
  // stall cycles keep resp_state non-idle, hold is how long the door stays open.
  task automatic run_request(input logic [3:0] code, input bit same_cycle, input int stall,
                             input int hold);
    bit grant;
    bit lock;
    int new_fails;
    int tv, gi, di, fin;
    logic [3:0] exp_fc;

    grant     = (code == secret);
    new_fails = grant ? 0 : ((fails >= 15) ? 15 : fails + 1);
    lock      = !grant && (new_fails == MAX_FAILS);
    tv        = stall;
    gi        = tv + 3;
    di        = tv + 1 + RESP_TIMEOUT;
    fin       = grant ? (gi + hold) : (lock ? (di + LOCKOUT_CYCLES) : di);

    if (same_cycle) begin
      apply_stimulus(1'b1, code, 1'b1, 1'b0);
      step();
    end else begin
      apply_stimulus(1'b1, 4'($urandom), 1'b0, 1'b0);
      step();
      apply_stimulus(1'b1, code, 1'b0, 1'b0);
      step();
      apply_stimulus(1'b0, 4'($urandom), 1'b1, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    check_output("req_busy", -1, 8'(busy), 8'd1);
    check_output("req_no_validate", -1, 8'(tif.validate_code), 8'd0);
    check_output("req_code", -1, 8'(tif.access_code), 8'(code));

    tif.resp_state = (stall > 0) ? 2'b10 : 2'b00;
    for (int t = 0; t <= fin + 1; t++) begin
      step();
      if (t < (grant ? gi : di)) exp_fc = 4'(fails);
      else if (lock && t >= fin) exp_fc = 4'd0;
      else exp_fc = 4'(new_fails);
      compare_all(t, t == tv, grant && t == gi, !grant && t == di,
                  lock && t >= di && t < fin, t < fin, (t < fin) ? code : 4'd0, exp_fc);
      tif.resp_state = (t + 1 < stall) ? 2'b10 : 2'b00;
      tif.door_open  = grant && (t + 1 >= gi) && (t + 1 < gi + hold);
      if (t < fin) begin
        apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end else begin
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
      end
    end
    fails = lock ? 0 : new_fails;
  endtask

  // Directed steps followed by a randomized transaction stream.
  initial begin
    checks = 0;
    errors = 0;
    fails  = 0;
    secret = 4'd9;
    reset  = 1'b1;
    tif.door_open  = 1'b0;
    tif.resp_state = 2'b00;
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset held while the keypad and door inputs toggle.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
      tif.door_open = 1'($urandom_range(0, 1));
      step();
      compare_all(i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    tif.door_open = 1'b0;
    reset = 1'b0;
    step();
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    compare_all(100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    compare_all(101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Granted request, denial, stalled responder, then three denials into lockout.
    run_request(4'd9, 1'b0, 0, 2);
    run_request(4'd2, 1'b0, 0, 1);
    run_request(4'd9, 1'b0, 3, 1);
    run_request(4'd0, 1'b0, 0, 1);
    run_request(4'd1, 1'b1, 1, 1);
    run_request(4'd15, 1'b0, 0, 1);

    // Digit and enter in the same cycle use the new digit.
    run_request(4'd5, 1'b1, 0, 1);

    // Clear wins over a same-cycle digit and enter; a bare enter afterwards does nothing.
    apply_stimulus(1'b1, 4'd7, 1'b0, 1'b0);
    step();
    check_output("digit_held", 200, 8'(tif.access_code), 8'd7);
    apply_stimulus(1'b1, 4'd4, 1'b1, 1'b1);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    compare_all(201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'(fails));
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    step();
    compare_all(202, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'(fails));

    // Reset in the middle of WAIT_RESP aborts without any pulse and clears the counter.
    apply_stimulus(1'b1, 4'd3, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
    step();
    check_output("abort_validate", 300, 8'(tif.validate_code), 8'd1);
    step();
    check_output("abort_in_wait", 301, 8'(busy), 8'd1);
    reset = 1'b1;
    step();
    compare_all(302, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    fails = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      compare_all(303 + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    end

    // Randomized transaction stream.
    for (int n = 0; n < 12; n++) begin
      logic [3:0] code;
      code = ($urandom_range(0, 1) == 1) ? secret : 4'($urandom);
      run_request(code, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
